// File: rtl/sram_io_pkg.sv
// Shared definitions for the serial burst SRAM controller: FSM state encoding,
// command frame layout helpers and the parity helper.
package sram_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WDAT = 3'd2,
    ST_WMEM = 3'd3,
    ST_RMEM = 3'd4,
    ST_RCAP = 3'd5,
    ST_RDAT = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  // Opcode position inside the command frame (first serial bit).
  localparam int WR_BIT = 0;

  // Command frame = WR + start address + burst length.
  function automatic int cmd_w(input int addr_w, input int len_w);
    return 1 + addr_w + len_w;
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sram_io_shreg.sv
// Right-shifting register with parallel load. Serial data enters at the MSB
// and leaves at bit 0. The look-ahead value lets the controller act on a
// frame in the same cycle its last bit arrives.
module sram_io_shreg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         BGN,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         sh_en,
  input  logic         si,
  output logic         so,
  output logic [W-1:0] q_nxt
);

  logic [W-1:0] q;

  // Parallel load takes priority over shifting.
  always_comb begin
    q_nxt = q;
    if (ld) begin
      q_nxt = ld_val;
    end else if (sh_en) begin
      q_nxt = {si, q[W-1:1]};
    end
  end

  // Register stage.
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

  assign so = q[0];

endmodule

// File: rtl/sram_burst_io_ctrl.sv
// Serial-command burst controller for a single-port SRAM.
// A serial frame (WR, start address, LEN) selects a burst of LEN+1 word
// writes or reads; the address auto-increments and wraps.
// Optional build macro: SRAM_IO_PARITY_EN adds an even-parity bit after each
// serial data word in both directions and a sticky ERR flag.
//
// state | meaning
// IDLE  | waiting for LOAD_N low
// CMD   | shifting in the command frame
// WDAT  | shifting in one write word (plus parity bit)
// WMEM  | single SRAM write access
// RMEM  | single SRAM read access
// RCAP  | capture PI into the shift register
// RDAT  | shifting out one read word (plus parity bit)
// DONE  | end-of-burst pulse
module sram_burst_io_ctrl
  import sram_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 4
) (
  input  logic              CLK,
  input  logic              BGN,
  input  logic              LOAD_N,
  input  logic              SI,
  input  logic [DATA_W-1:0] PI,
  output logic              SO,
  output logic              SO_VLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] PO
);

`ifdef SRAM_IO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CMD_W = cmd_w(ADDR_W, LEN_W);
  // serial bits per data word
  localparam int BPW   = DATA_W + PAR_BITS;
  // one register serves both the command frame and the data words
  localparam int SH_W  = (CMD_W > BPW) ? CMD_W : BPW;
  localparam int CNT_W = $clog2(SH_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              err_q, err_d;

  logic              cen_d, wen_d, so_vld_d, busy_d, done_d;
  logic [ADDR_W-1:0] a_d;
  logic [DATA_W-1:0] po_d;

  logic              sh_ld, sh_en;
  logic [SH_W-1:0]   sh_ld_val, sh_nxt;
  logic [CMD_W-1:0]  frame;
  logic [BPW-1:0]    wframe;
  logic [DATA_W-1:0] wword;

  // Frames are left-aligned once their last bit has been shifted in.
  assign frame  = sh_nxt[SH_W-1 -: CMD_W];
  assign wframe = sh_nxt[SH_W-1 -: BPW];
  assign wword  = wframe[DATA_W-1:0];

`ifdef SRAM_IO_PARITY_EN
  assign sh_ld_val = SH_W'({even_par(64'(PI)), PI});
`else
  assign sh_ld_val = SH_W'(PI);
`endif

  sram_io_shreg #(
    .W(SH_W)
  ) u_shreg (
    .CLK    (CLK),
    .BGN    (BGN),
    .ld     (sh_ld),
    .ld_val (sh_ld_val),
    .sh_en  (sh_en),
    .si     (SI),
    .so     (SO),
    .q_nxt  (sh_nxt)
  );

  // Next-state logic, bit/word down-counters and address stepping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    left_d  = left_q;
    err_d   = err_q;
    sh_ld   = 1'b0;
    sh_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!LOAD_N) begin
          state_d = ST_CMD;
          cnt_d   = CNT_W'(CMD_W - 1);
          err_d   = 1'b0;
        end
      end
      ST_CMD: begin
        sh_en = 1'b1;
        if (cnt_q == '0) begin
          addr_d = frame[ADDR_W:1];
          left_d = frame[CMD_W-1 -: LEN_W];
          if (frame[WR_BIT]) begin
            state_d = ST_WDAT;
            cnt_d   = CNT_W'(BPW - 1);
          end else begin
            state_d = ST_RMEM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WDAT: begin
        sh_en = 1'b1;
        if (cnt_q == '0) begin
`ifdef SRAM_IO_PARITY_EN
          // a corrupted word is dropped and the burst is abandoned
          if (even_par(64'(wword)) != wframe[DATA_W]) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WMEM;
          end
`else
          state_d = ST_WMEM;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WMEM: begin
        addr_d = addr_q + ADDR_W'(1);
        if (left_q == '0) begin
          state_d = ST_DONE;
        end else begin
          left_d  = left_q - LEN_W'(1);
          state_d = ST_WDAT;
          cnt_d   = CNT_W'(BPW - 1);
        end
      end
      ST_RMEM: begin
        state_d = ST_RCAP;
      end
      ST_RCAP: begin
        sh_ld   = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_RDAT;
        cnt_d   = CNT_W'(BPW - 1);
      end
      ST_RDAT: begin
        sh_en = 1'b1;
        if (cnt_q == '0) begin
          if (left_q == '0) begin
            state_d = ST_DONE;
          end else begin
            left_d  = left_q - LEN_W'(1);
            state_d = ST_RMEM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the upcoming state so the pins are registered.
  always_comb begin
    cen_d    = !((state_d == ST_WMEM) || (state_d == ST_RMEM));
    wen_d    = (state_d != ST_WMEM);
    a_d      = cen_d ? '0 : addr_d;
    po_d     = (state_d == ST_WMEM) ? wword : '0;
    so_vld_d = (state_d == ST_RDAT);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
      CEN     <= 1'b1;
      WEN     <= 1'b1;
      A       <= '0;
      PO      <= '0;
      SO_VLD  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      err_q   <= err_d;
      CEN     <= cen_d;
      WEN     <= wen_d;
      A       <= a_d;
      PO      <= po_d;
      SO_VLD  <= so_vld_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_sram_burst_io_ctrl.sv
// Self-checking bench for sram_burst_io_ctrl: directed cases plus random
// bursts, checked against an array model of memory contents and the
// per-word cycle costs.
module tb_sram_burst_io_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 4;
  localparam int CMD_W  = 1 + ADDR_W + LEN_W;
`ifdef SRAM_IO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BPW   = DATA_W + PB;
  localparam int MEM_N = 1 << ADDR_W;

  logic              CLK    = 1'b0;
  logic              BGN    = 1'b0;
  logic              LOAD_N = 1'b1;
  logic              SI     = 1'b0;
  logic [DATA_W-1:0] PI     = '0;
  logic              SO, SO_VLD, BUSY, DONE, ERR, CEN, WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] PO;

  sram_burst_io_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .CLK    (CLK),
    .BGN    (BGN),
    .LOAD_N (LOAD_N),
    .SI     (SI),
    .PI     (PI),
    .SO     (SO),
    .SO_VLD (SO_VLD),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR),
    .CEN    (CEN),
    .WEN    (WEN),
    .A      (A),
    .PO     (PO)
  );

  always #5 CLK = ~CLK;

  // SRAM environment with a backdoor port for preloading.
  logic [DATA_W-1:0] sram    [MEM_N];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_a  = '0;
  logic [DATA_W-1:0] bd_d  = '0;

  always @(posedge CLK) begin
    if (bd_we) sram[bd_a] <= bd_d;
    else if (!CEN && !WEN) sram[A] <= PO;
    if (!CEN && WEN) PI <= sram[A];
  end

  // Bus monitor: logs accesses and serial bits, counts rule violations.
  int unsigned cyc = 0, busy_cyc = 0, done_cnt = 0, viol = 0;
  int unsigned cen_cyc = 0, vld_cyc = 0, done_cyc = 0;
  logic        prev_cen_low = 1'b0;
  logic [ADDR_W+DATA_W-1:0] wr_log[$];
  logic [ADDR_W-1:0]        rd_log[$];
  logic                     so_log[$];

  always @(negedge CLK) begin
    cyc++;
    if (BUSY) busy_cyc++;
    if (DONE) begin done_cnt++; done_cyc = cyc; end
    if (!CEN) cen_cyc = cyc;
    if (!CEN && !WEN) wr_log.push_back({A, PO});
    if (!CEN && WEN) rd_log.push_back(A);
    if (SO_VLD) begin so_log.push_back(SO); vld_cyc = cyc; end
    if (!WEN && CEN) viol++;
    if (CEN && (A != '0 || PO != '0)) viol++;
    if (!CEN && prev_cen_low) viol++;
    prev_cen_low = !CEN;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int a, input logic [DATA_W-1:0] d);
    @(negedge CLK);
    bd_we = 1'b1; bd_a = ADDR_W'(a); bd_d = d;
    ref_mem[a] = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      LOAD_N = 1'b1;
      SI = v[i];
    end
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len);
    logic [CMD_W-1:0] c;
    c = {len[LEN_W-1:0], addr[ADDR_W-1:0], wr};
    @(negedge CLK);
    LOAD_N = 1'b0;
    SI = 1'($urandom);
    send_bits(64'(c), CMD_W);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic flip_par);
    logic [DATA_W:0] f;
    f = {(^d) ^ flip_par, d};
    send_bits(64'(f), BPW);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " timeout"}, 64'(n < 3000), 64'(1));
  endtask

  task automatic txn_write(input string tag, input int addr, input int len,
                           input logic [DATA_W-1:0] dq[$]);
    int wb, bb, db, vb, n;
    logic [ADDR_W-1:0] ea;
    wb = wr_log.size(); bb = busy_cyc; db = done_cnt; vb = viol; n = len + 1;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i < n; i++) begin
      send_word(dq[i], 1'b0);
      @(negedge CLK);
      SI = 1'($urandom);
    end
    wait_idle(tag);
    check({tag, " nwr"}, 64'(wr_log.size() - wb), 64'(n));
    for (int i = 0; i < n; i++) begin
      ea = ADDR_W'((addr + i) % MEM_N);
      if (wb + i < wr_log.size())
        check({tag, " wr"}, 64'(wr_log[wb + i]), 64'({ea, dq[i]}));
      ref_mem[ea] = dq[i];
    end
    check({tag, " done"}, 64'(done_cnt - db), 64'(1));
    check({tag, " busy"}, 64'(busy_cyc - bb), 64'(CMD_W + n * (BPW + 1) + 1));
    check({tag, " rules"}, 64'(viol - vb), 64'(0));
    check({tag, " done_lat"}, 64'(done_cyc - cen_cyc), 64'(1));
    check({tag, " err"}, 64'(ERR), 64'(0));
  endtask

  task automatic txn_read(input string tag, input int addr, input int len, input logic poke);
    int rb, sb, bb, db, vb, n, k;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] w;
    rb = rd_log.size(); sb = so_log.size(); bb = busy_cyc; db = done_cnt; vb = viol;
    n = len + 1;
    send_cmd(1'b0, addr, len);
    if (poke) begin
      k = 0;
      while (!SO_VLD && k < 200) begin
        @(negedge CLK);
        k++;
      end
      check({tag, " vld_wait"}, 64'(k < 200), 64'(1));
      LOAD_N = 1'b0;
      @(negedge CLK);
      LOAD_N = 1'b1;
    end
    wait_idle(tag);
    check({tag, " nrd"}, 64'(rd_log.size() - rb), 64'(n));
    check({tag, " nbits"}, 64'(so_log.size() - sb), 64'(n * BPW));
    for (int i = 0; i < n; i++) begin
      ea = ADDR_W'((addr + i) % MEM_N);
      if (rb + i < rd_log.size())
        check({tag, " rd_addr"}, 64'(rd_log[rb + i]), 64'(ea));
      w = '0;
      for (int b = 0; b < DATA_W; b++)
        if (sb + i * BPW + b < so_log.size()) w[b] = so_log[sb + i * BPW + b];
      check({tag, " rd_data"}, 64'(w), 64'(ref_mem[ea]));
`ifdef SRAM_IO_PARITY_EN
      if (sb + i * BPW + DATA_W < so_log.size())
        check({tag, " rd_par"}, 64'(so_log[sb + i * BPW + DATA_W]), 64'(^ref_mem[ea]));
`endif
    end
    check({tag, " done"}, 64'(done_cnt - db), 64'(1));
    check({tag, " busy"}, 64'(busy_cyc - bb), 64'(CMD_W + n * (BPW + 2) + 1));
    check({tag, " rules"}, 64'(viol - vb), 64'(0));
    check({tag, " done_lat"}, 64'(done_cyc - vld_cyc), 64'(1));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] dq[$];
    logic [DATA_W-1:0] v;
    int a, l, wb, db;

    // fill memory through the backdoor while held in reset
    for (int i = 0; i < MEM_N; i++) begin
      @(negedge CLK);
      v = DATA_W'($urandom);
      bd_we = 1'b1; bd_a = ADDR_W'(i); bd_d = v;
      ref_mem[i] = v;
    end
    @(negedge CLK);
    bd_we = 1'b0;
    check("rst cen", 64'(CEN), 64'(1));
    check("rst wen", 64'(WEN), 64'(1));
    check("rst a", 64'(A), 64'(0));
    check("rst po", 64'(PO), 64'(0));
    check("rst so", 64'(SO), 64'(0));
    check("rst so_vld", 64'(SO_VLD), 64'(0));
    check("rst busy", 64'(BUSY), 64'(0));
    check("rst done", 64'(DONE), 64'(0));
    check("rst err", 64'(ERR), 64'(0));
    BGN = 1'b1;
    repeat (3) @(negedge CLK);

    dq = '{8'hA5};
    txn_write("wr1", 'h005, 0, dq);

    bd_write('h010, 8'h11);
    bd_write('h011, 8'h22);
    bd_write('h012, 8'h33);
    txn_read("rd3", 'h010, 2, 1'b0);

    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    txn_write("wrap", 'h1FE, 3, dq);
    txn_read("wrap_rd", 'h1FE, 3, 1'b0);

    // asynchronous reset during the second word of a 4-word write
    send_cmd(1'b1, 'h040, 3);
    send_word(8'h5C, 1'b0);
    @(negedge CLK);
    SI = 1'b0;
    send_bits(64'h3, 3);
    #2 BGN = 1'b0;
    #1;
    check("arst cen", 64'(CEN), 64'(1));
    check("arst wen", 64'(WEN), 64'(1));
    check("arst busy", 64'(BUSY), 64'(0));
    check("arst a", 64'(A), 64'(0));
    ref_mem['h040] = 8'h5C;
    @(negedge CLK);
    @(negedge CLK);
    BGN = 1'b1;
    @(negedge CLK);
    dq = '{8'hC3};
    txn_write("post_rst", 'h100, 0, dq);
    txn_read("post_rst_rd", 'h040, 1, 1'b0);

    txn_read("maxlen", 'h0F8, 15, 1'b1);

`ifdef SRAM_IO_PARITY_EN
    wb = wr_log.size(); db = done_cnt;
    send_cmd(1'b1, 'h080, 0);
    send_word(8'h03, 1'b1);
    wait_idle("par");
    check("par nwr", 64'(wr_log.size() - wb), 64'(0));
    check("par err", 64'(ERR), 64'(1));
    check("par done", 64'(done_cnt - db), 64'(1));
    repeat (2) @(negedge CLK);
    check("par err sticky", 64'(ERR), 64'(1));
    txn_read("par_rd", 'h080, 0, 1'b0);
`else
    wb = wr_log.size(); db = done_cnt;
`endif

    for (int t = 0; t < 24; t++) begin
      a = $urandom_range(MEM_N - 1);
      l = $urandom_range((1 << LEN_W) - 1);
      if ($urandom_range(1) == 1) begin
        dq.delete();
        for (int i = 0; i <= l; i++) dq.push_back(DATA_W'($urandom));
        txn_write("rnd_wr", a, l, dq);
      end else begin
        txn_read("rnd_rd", a, l, 1'($urandom_range(1)));
      end
      repeat ($urandom_range(3)) @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
